tdm_demux8: RTL and testbench
=============================

# tdm_demux8

Time-division demultiplexer that reassembles an 8-bit word from the serial output of an 8:1 mux scanned by a 3-bit select. It is the receive end of the mux-based serial link: one data bit per valid cycle, tagged with its select index, collected into an 8-bit register. A completed word is presented through a valid/ready handshake.

## Interface
Parameters:
- none (width fixed at 8 lanes, 3-bit select)

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  `in_bit`/`in_sel` carry a sample this cycle
- `in_bit`  input  1  muxed data bit (mux `out`)
- `in_sel`  input  3  select index the bit was taken with
- `out`  output  8  reassembled word; `out[i]` = bit received with `sel = i`
- `out_valid`  output  1  `out` holds a complete, unaccepted word
- `out_ready`  input  1  consumer accepts `out` when `out_valid && out_ready`
- `busy`  output  1  a frame is partially collected
- `err`  output  1  one-cycle pulse: sequence error or overrun

## Operation
- Internal state: `shadow[7:0]` collection register, `cnt[2:0]` expected index, FSM {IDLE, COLLECT}.
- IDLE: `cnt = 0`. An accepted sample with `in_sel == 0` writes `shadow[0]`, sets `cnt = 1`, enters COLLECT. A sample with `in_sel != 0` is dropped and pulses `err`.
- COLLECT: an accepted sample with `in_sel == cnt` writes `shadow[cnt]` and increments `cnt`.
- On the sample with `in_sel == 7`, the frame completes. `out <= {in_bit, shadow[6:0]}`, `out_valid <= 1`, return to IDLE.
- Sequence error in COLLECT (`in_sel != cnt`):
  - pulse `err`;
  - discard the partial frame;
  - if `in_sel == 0`, restart the frame with this bit (`cnt = 1`, stay in COLLECT);
  - otherwise go to IDLE.
- Cycles with `in_valid = 0` are gaps. State holds, and there is no timeout.
- Handshake:
  - `out` is stable while `out_valid = 1`.
  - `out_valid` clears on the cycle after `out_valid && out_ready`.
- Overrun: a frame completes while `out_valid = 1` and `out_ready = 0`.
  - The new word replaces `out`, `out_valid` stays 1, and `err` pulses.
  - If `out_ready = 1` in that same cycle, the old word is accepted, the new word loads, and there is no error.
- `busy = (state == COLLECT)`.

## Timing
- Reset values: `out = 8'h00`, `out_valid = 0`, `busy = 0`, `err = 0`, `cnt = 0`, state IDLE, `shadow = 0`.
- `rst` overrides everything, including mid-frame and with `out_valid` pending; the partial frame and the pending word are lost.
- Latency: `out_valid` rises on the clock edge that samples the `in_sel = 7` bit. At best this is 8 consecutive valid cycles after the frame start.
- Throughput: one word per 8 valid cycles; back-to-back frames need no idle cycle.
- `err` is registered, high for exactly one cycle, and aligned to the edge that detected the fault.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `TDM_DEMUX_SEL_CHECK_EN` defined:
  - the sequence checking above applies;
  - `in_sel` must match `cnt`.
- Not defined:
  - `in_sel` is ignored and the bit is written to `shadow[cnt]` unconditionally;
  - a frame completes when `cnt == 7`;
  - sequence `err` never fires; overrun `err` still fires.

## Test plan
- Reset, then 8 valid cycles with `in = 8'b10110011`, `in_sel = 0..7`, `in_bit = in[in_sel]`, `out_ready = 1` -> `out = 8'b10110011` and `out_valid` high for 1 cycle on the 8th edge; `err` stays 0.
- Same frame with 3 `in_valid = 0` gap cycles after `sel = 3` -> same `out`; `busy = 1` through the gaps.
- With check enabled, `sel` sequence 0,1,2,5 -> `err` pulse at `sel 5`, state IDLE; then a clean 0..7 frame with `8'hA5` -> `out = 8'hA5`.
- Sequence 0,1,0..7 carrying `8'h3C` -> one `err` at the second `sel 0`, then `out = 8'h3C` with no further `err`.
- `out_ready = 0`, two frames `8'h11` then `8'h22` -> after the first, `out = 8'h11`; at the end of the second, `out = 8'h22`, `err` pulses, and `out_valid` stays high until `out_ready`.
- `rst` asserted after `sel 4` of a frame, then a full frame `8'hF0` -> all outputs return to reset values, then `out = 8'hF0`.

Source files
------------

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux8
// Purpose  : Receive end of a mux-based serial link. Collects one data bit per
//            valid cycle, tagged with its 3-bit select index, into an 8-bit
//            word and presents each completed word via valid/ready.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            in_valid   - in_bit/in_sel carry a sample this cycle
//            in_bit     - muxed serial data bit
//            in_sel     - select index the bit was taken with
//            out        - reassembled word, out[i] = bit received with sel=i
//            out_valid  - out holds a complete, unaccepted word
//            out_ready  - consumer accepts out when out_valid && out_ready
//            busy       - a frame is partially collected
//            err        - one-cycle pulse on sequence error or overrun
// Config   : TDM_DEMUX_SEL_CHECK_EN - when defined, in_sel must match the
//            expected index; otherwise in_sel is ignored and bits fill
//            positions in arrival order.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic [2:0] in_sel,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;

  logic       w_match;
  logic       w_done;
  logic [7:0] w_word;
  logic       w_seq_err;

`ifdef TDM_DEMUX_SEL_CHECK_EN
  assign w_match = (in_sel == cnt_q);
`else
  // Position comes purely from arrival order; the mismatch path below is
  // never taken in this build.
  assign w_match = 1'b1;
`endif

  // Frame collection. cnt_q is 0 whenever the FSM is idle, so the same
  // "index matches cnt" rule covers both frame start and continuation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    w_done    = 1'b0;
    w_word    = 8'h00;
    w_seq_err = 1'b0;
    if (in_valid) begin
      if (w_match) begin
        if (cnt_q == 3'd7) begin
          // Last bit bypasses shadow so the word is ready on this edge.
          w_done  = 1'b1;
          w_word  = {in_bit, shadow_q[6:0]};
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          shadow_d[cnt_q] = in_bit;
          cnt_d           = cnt_q + 3'd1;
          state_d         = ST_COLLECT;
        end
      end else begin
        w_seq_err = 1'b1;
        shadow_d  = 8'h00;
        if (in_sel == 3'd0) begin
          // A fresh frame start mid-frame: drop the partial, keep this bit.
          shadow_d[0] = in_bit;
          cnt_d       = 3'd1;
          state_d     = ST_COLLECT;
        end else begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Output word and handshake. A completing frame always loads; it is an
  // overrun only if the previous word is still pending and not accepted now.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = w_seq_err;
    if (w_done) begin
      out_d       = w_word;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        err_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      shadow_q    <= 8'h00;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_COLLECT);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux8
// Purpose  : Self-checking bench for tdm_demux8. A queue-based reference
//            model predicts all outputs every cycle; directed frames plus a
//            few literal expectations pin the model to known answers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic [2:0] in_sel = 3'd0;
  logic       out_ready = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  tdm_demux8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sel    (in_sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The frame under collection is just the list of bits received so far;
  // its length is the next index expected.
  bit         m_bits[$];
  logic [7:0] m_out = 8'h00;
  bit         m_ov  = 1'b0;
  bit         m_err = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_done;
  bit         m_e;
  logic [7:0] m_w;

  always @(posedge clk) begin
    if (rst) begin
      m_bits.delete();
      m_out = 8'h00; m_ov = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      m_e    = 1'b0;
      m_w    = 8'h00;
      if (in_valid) begin
`ifdef TDM_DEMUX_SEL_CHECK_EN
        if (int'(in_sel) == m_bits.size()) begin
          m_bits.push_back(in_bit);
        end else begin
          m_e = 1'b1;
          m_bits.delete();
          if (in_sel == 3'd0) m_bits.push_back(in_bit);
        end
`else
        m_bits.push_back(in_bit);
`endif
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) m_w[i] = m_bits[i];
          m_done = 1'b1;
          m_bits.delete();
        end
      end
      if (m_done) begin
        if (m_ov && !out_ready) m_e = 1'b1;
        m_out = m_w;
        m_ov  = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      m_err  = m_e;
      m_busy = (m_bits.size() != 0);
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      n_cmp++;
      if (out !== m_out || out_valid !== m_ov || busy !== m_busy || err !== m_err) begin
        n_bad++;
        $display("FAIL cycle @%0t: got out=%h ov=%b busy=%b err=%b, expected out=%h ov=%b busy=%b err=%b",
                 $time, out, out_valid, busy, err, m_out, m_ov, m_busy, m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input bit b, input logic [2:0] s, input bit r);
    in_valid  = v;
    in_bit    = b;
    in_sel    = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input bit b, input logic [2:0] s, input bit r);
    step(1'b1, b, s, r);
  endtask

  task automatic gap(input bit r);
    step(1'b0, 1'b0, 3'd0, r);
  endtask

  // Full frame; out_ready is held at r for sel 0..6 and rlast on sel 7.
  task automatic frame(input logic [7:0] w, input bit r, input bit rlast);
    for (int s = 0; s < 8; s++) smp(w[s], 3'(s), (s == 7) ? rlast : r);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    cmp_on = 1'b1;
    @(posedge clk); #1;
    chk("rst_out", out, 8'h00);
    chk("rst_ov", {7'b0, out_valid}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    rst = 1'b0;

    // Clean frame, consumer always ready.
    frame(8'b10110011, 1'b1, 1'b1);
    chk("f1_out", out, 8'b10110011);
    chk("f1_ov", {7'b0, out_valid}, 8'h01);
    chk("f1_err", {7'b0, err}, 8'h00);
    gap(1'b1);
    chk("f1_ov_clr", {7'b0, out_valid}, 8'h00);

    // Same frame with gaps after sel 3.
    for (int s = 0; s < 4; s++) smp(1'((8'b10110011 >> s) & 8'h01), 3'(s), 1'b1);
    for (int g = 0; g < 3; g++) begin
      gap(1'b1);
      chk("gap_busy", {7'b0, busy}, 8'h01);
    end
    for (int s = 4; s < 8; s++) smp(1'((8'b10110011 >> s) & 8'h01), 3'(s), 1'b1);
    chk("gap_out", out, 8'b10110011);
    chk("gap_ov", {7'b0, out_valid}, 8'h01);

    // Sequence 0,1,2,5 then a clean A5 frame.
    smp(1'b1, 3'd0, 1'b1);
    smp(1'b0, 3'd1, 1'b1);
    smp(1'b1, 3'd2, 1'b1);
    smp(1'b0, 3'd5, 1'b1);
`ifdef TDM_DEMUX_SEL_CHECK_EN
    chk("seq5_err", {7'b0, err}, 8'h01);
    chk("seq5_busy", {7'b0, busy}, 8'h00);
`endif
    frame(8'hA5, 1'b1, 1'b1);
`ifdef TDM_DEMUX_SEL_CHECK_EN
    chk("a5_out", out, 8'hA5);
`endif

    // Sequence 0,1 then restart 0..7 carrying 3C.
    smp(1'b0, 3'd0, 1'b1);
    smp(1'b0, 3'd1, 1'b1);
    smp(1'b0, 3'd0, 1'b1);
`ifdef TDM_DEMUX_SEL_CHECK_EN
    chk("restart_err", {7'b0, err}, 8'h01);
    chk("restart_busy", {7'b0, busy}, 8'h01);
`endif
    for (int s = 1; s < 8; s++) smp(1'((8'h3C >> s) & 8'h01), 3'(s), 1'b1);
`ifdef TDM_DEMUX_SEL_CHECK_EN
    chk("3c_out", out, 8'h3C);
    chk("3c_err", {7'b0, err}, 8'h00);
`endif

    // Reset mid-frame after sel 4, then a full F0 frame.
    for (int s = 0; s < 5; s++) smp(1'((8'hF0 >> s) & 8'h01), 3'(s), 1'b0);
    rst = 1'b1;
    gap(1'b0);
    chk("mid_rst_out", out, 8'h00);
    chk("mid_rst_busy", {7'b0, busy}, 8'h00);
    chk("mid_rst_ov", {7'b0, out_valid}, 8'h00);
    rst = 1'b0;
    frame(8'hF0, 1'b0, 1'b0);
    chk("f0_out", out, 8'hF0);

    // Overrun: F0 still pending, 11 arrives with no ready -> err.
    frame(8'h11, 1'b0, 1'b0);
    chk("ovr1_out", out, 8'h11);
    chk("ovr1_err", {7'b0, err}, 8'h01);
    frame(8'h22, 1'b0, 1'b0);
    chk("ovr2_out", out, 8'h22);
    chk("ovr2_err", {7'b0, err}, 8'h01);
    gap(1'b0);
    chk("ovr_hold_ov", {7'b0, out_valid}, 8'h01);
    chk("ovr_hold_err", {7'b0, err}, 8'h00);
    // Pending word accepted on the same edge a new one completes: no err.
    frame(8'h5A, 1'b0, 1'b1);
    chk("swap_out", out, 8'h5A);
    chk("swap_err", {7'b0, err}, 8'h00);
    chk("swap_ov", {7'b0, out_valid}, 8'h01);
    gap(1'b1);
    chk("final_ov", {7'b0, out_valid}, 8'h00);
    gap(1'b0);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
